// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: state encoding,
// minimum legal ratio and the ratio clamp applied on configuration accept.
package clk_div_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned MIN_DIV = 2;

  // Ratios below MIN_DIV cannot form a high and a low phase, so they are raised.
  function automatic logic [31:0] clamp_div(input logic [31:0] req);
    return (req < MIN_DIV) ? 32'(MIN_DIV) : req;
  endfunction

endpackage

// File: rtl/clk_div_half_ext.sv
// Falling-edge stretch flop: extends the high phase by half a clk cycle for
// odd ratios so the divided clock keeps a 50% duty cycle.
module clk_div_half_ext (
  input  logic clk_i,
  input  logic rst_i,
  input  logic p_i,
  input  logic odd_i,
  output logic n_o
);

  logic n_q;

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_i & odd_i;
    end
  end

  assign n_o = n_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty integer clock divider with glitch-free ratio
// reload and start/stop, both taking effect only at a period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [DIV_W-1:0] cur_div,
  output logic             active,
  output logic             period_tick,
  output logic             clk_out
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [0:0]       state_q,   state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             cur_odd_q, cur_odd_d;
  logic [DIV_W-1:0] cnt_q,     cnt_d;
  logic             pend_q,    pend_d;
  logic [DIV_W-1:0] shadow_q,  shadow_d;
  logic             p_q,       p_d;
  logic             tick_q,    tick_d;

  logic             n_q;
  logic             accept;
  logic             at_bound;
  logic             apply;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] half_div;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] cfg_clamped;

  assign cfg_clamped = DIV_W'(clamp_div(32'(cfg_div)));
  assign accept      = cfg_valid & ~pend_q;

  // IDLE counts as a boundary every cycle so a pending ratio lands before the first period.
  assign at_bound = (state_q == ST_RUN) ? (cnt_q == (cur_div_q - ONE)) : 1'b1;
  assign apply    = pend_q & at_bound;
  assign eff_div  = apply ? shadow_q : cur_div_q;
  assign half_div = cur_div_q >> 1;
  assign cnt_inc  = cnt_q + ONE;

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    cur_odd_d = cur_odd_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    shadow_d  = shadow_q;
    p_d       = p_q;
    tick_d    = 1'b0;

    if (apply) begin
      cur_div_d = shadow_q;
      cur_odd_d = shadow_q[0];
      pend_d    = 1'b0;
    end

    if (accept) begin
      pend_d   = 1'b1;
      shadow_d = cfg_clamped;
    end

    if (at_bound) begin
      if (en) begin
        state_d = ST_RUN;
        cnt_d   = '0;
        p_d     = 1'b1;
        tick_d  = 1'b1;
      end else begin
        // Park so that a later enable restarts cleanly from the boundary.
        state_d = ST_IDLE;
        cnt_d   = eff_div - ONE;
        p_d     = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc;
      p_d   = (cnt_inc < half_div);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_div_q <= DIV_RST;
      cur_odd_q <= DIV_RST[0];
      cnt_q     <= DIV_RST - ONE;
      pend_q    <= 1'b0;
      shadow_q  <= DIV_RST;
      p_q       <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      cur_odd_q <= cur_odd_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      shadow_q  <= shadow_d;
      p_q       <= p_d;
      tick_q    <= tick_d;
    end
  end

  clk_div_half_ext u_half_ext (
    .clk_i (clk_in),
    .rst_i (rst),
    .p_i   (p_q),
    .odd_i (cur_odd_q),
    .n_o   (n_q)
  );

  assign clk_out     = p_q | n_q;
  assign cfg_ready   = ~pend_q;
  assign cur_div     = cur_div_q;
  assign active      = (state_q == ST_RUN);
  assign period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a cycle table for reload/handshake timing
// plus edge-timed sequences for ratio switches, stop and reset.
`timescale 1ns/1ps
module tb_clk_div_prog;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic [7:0] cur_div;
  logic       active;
  logic       period_tick;
  logic       clk_out;

  int checks;
  int failures;

  clk_div_prog #(.DIV_W(8), .DIV_DEFAULT(3)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .cur_div     (cur_div),
    .active      (active),
    .period_tick (period_tick),
    .clk_out     (clk_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Edge monitor on the divided clock.
  time t_rise;
  time last_period;
  time last_high;
  time min_high;
  int  rises;

  initial begin
    t_rise = 0; last_period = 0; last_high = 0; min_high = 1000; rises = 0;
  end

  always @(posedge clk_out) begin
    if (rises > 0) last_period = $time - t_rise;
    t_rise = $time;
    rises++;
  end

  always @(negedge clk_out) begin
    if (rises > 0) begin
      last_high = $time - t_rise;
      if (last_high < min_high) min_high = last_high;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      step();
      if (period_tick) seen++;
    end
    chk("wait_ticks", 64'(seen), 64'(n));
  endtask

  task automatic wait_cur(input logic [7:0] exp, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (cur_div == exp) ok = 1'b1;
    end
    chk("wait_cur_div", {56'd0, cur_div}, {56'd0, exp});
  endtask

  typedef struct {
    logic       en;
    logic       cv;
    logic [7:0] cd;
    logic [7:0] e_cur;
    logic       e_rdy;
    logic       e_act;
    logic       e_tick;
    logic       e_clk;
  } vec_t;

  vec_t tv [24];

  initial begin
    time t0;
    time t_stop;
    int  r0;
    checks = 0;
    failures = 0;

    // inputs driven after sampling row r take effect at the next posedge
    tv[0]  = '{1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[1]  = '{1'b1, 1'b1, 8'd4, 8'd3, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 8'd9, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 8'd5, 8'd4, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[12] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[13] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[14] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[15] = '{1'b1, 1'b1, 8'd0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[16] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b1, 1'b1};
    tv[17] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[18] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[19] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[20] = '{1'b1, 1'b0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[21] = '{1'b1, 1'b0, 8'd0, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[22] = '{1'b1, 1'b0, 8'd0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[23] = '{1'b1, 1'b0, 8'd0, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    #12;
    chk("rst_cur_div", {56'd0, cur_div}, 64'd3);
    chk("rst_active", {63'd0, active}, 64'd0);
    chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rst_tick", {63'd0, period_tick}, 64'd0);
    chk("rst_clk_out", {63'd0, clk_out}, 64'd0);

    en = 1'b1;
    @(posedge clk_in);
    #1 rst = 1'b0;

    for (int r = 0; r < 24; r++) begin
      step();
      chk($sformatf("row%0d_cur_div", r), {56'd0, cur_div}, {56'd0, tv[r].e_cur});
      chk($sformatf("row%0d_cfg_ready", r), {63'd0, cfg_ready}, {63'd0, tv[r].e_rdy});
      chk($sformatf("row%0d_active", r), {63'd0, active}, {63'd0, tv[r].e_act});
      chk($sformatf("row%0d_tick", r), {63'd0, period_tick}, {63'd0, tv[r].e_tick});
      chk($sformatf("row%0d_clk_out", r), {63'd0, clk_out}, {63'd0, tv[r].e_clk});
      if (r == 21) chk("min_high_ge_15", 64'(min_high >= 15), 64'd1);
      en = tv[r].en; cfg_valid = tv[r].cv; cfg_div = tv[r].cd;
    end

    // ratio 8, then reload 7 mid-period
    cfg_valid = 1'b1; cfg_div = 8'd8;
    step();
    cfg_valid = 1'b0;
    wait_cur(8'd8, 10);
    wait_ticks(1, 20);
    chk("n8_period", 64'(last_period), 64'd80);
    chk("n8_high", 64'(last_high), 64'd40);
    step();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd7;
    step();
    cfg_valid = 1'b0;
    chk("n8_pend_ready", {63'd0, cfg_ready}, 64'd0);
    wait_ticks(1, 20);
    chk("n8_last_period", 64'(last_period), 64'd80);
    chk("n7_cur_div", {56'd0, cur_div}, 64'd7);
    wait_ticks(1, 20);
    chk("n7_period", 64'(last_period), 64'd70);
    chk("n7_high", 64'(last_high), 64'd35);

    // ratio 1 clamps to 2
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    wait_cur(8'd2, 20);
    wait_ticks(2, 20);
    chk("n2_period", 64'(last_period), 64'd20);
    chk("n2_high", 64'(last_high), 64'd10);

    // ratio 6, drop en at cnt=1
    cfg_valid = 1'b1; cfg_div = 8'd6;
    step();
    cfg_valid = 1'b0;
    wait_cur(8'd6, 20);
    t0 = t_rise;
    step();
    en = 1'b0;
    for (int i = 0; i < 20 && active; i++) step();
    t_stop = $time - 1;
    chk("stop_active", {63'd0, active}, 64'd0);
    chk("stop_elapsed", 64'(t_stop - t0), 64'd60);
    chk("stop_high", 64'(last_high), 64'd30);
    chk("stop_clk_low", {63'd0, clk_out}, 64'd0);
    r0 = rises;
    for (int i = 0; i < 10; i++) step();
    chk("idle_no_rise", 64'(rises), 64'(r0));
    chk("idle_clk_low", {63'd0, clk_out}, 64'd0);
    chk("idle_cur_div", {56'd0, cur_div}, 64'd6);

    // pending ratio together with en rising in IDLE
    cfg_valid = 1'b1; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0; en = 1'b1;
    step();
    chk("start_cur_div", {56'd0, cur_div}, 64'd4);
    chk("start_active", {63'd0, active}, 64'd1);
    chk("start_tick", {63'd0, period_tick}, 64'd1);
    chk("start_clk_out", {63'd0, clk_out}, 64'd1);
    wait_ticks(1, 20);
    chk("start_period", 64'(last_period), 64'd40);

    // reset during a high phase
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clk_out", {63'd0, clk_out}, 64'd0);
    chk("async_rst_cur_div", {56'd0, cur_div}, 64'd3);
    chk("async_rst_active", {63'd0, active}, 64'd0);
    chk("async_rst_ready", {63'd0, cfg_ready}, 64'd1);
    chk("async_rst_tick", {63'd0, period_tick}, 64'd0);
    en = 1'b0;
    step();
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
